// File: rtl/fpu_div_issue_if.sv
// Handshake and divider-side signal bundle for the divide issue stage.
// The slave modport is the issue stage's view; master is the surrounding FPU and divider.
interface fpu_div_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_en;
  logic [31:0] div_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_dz;
  logic        out_invalid;
  logic        busy;

  modport slave (
    input  in_valid, in_a, in_b, div_result, out_ready,
    output in_ready, div_a, div_b, div_en, out_valid, out_data, out_dz, out_invalid, busy
  );

  modport master (
    output in_valid, in_a, in_b, div_result, out_ready,
    input  in_ready, div_a, div_b, div_en, out_valid, out_data, out_dz, out_invalid, busy
  );
endinterface

// File: rtl/fpu_div_issue.sv
// Issue/capture stage for the multicycle combinational divider: screens special
// operands, holds operands for a settle window, pulses div_en, captures the quotient.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | operands settling through the divider, counter running down
// FIRE  | div_en high, divider registers its quotient at the end of this cycle
// LATCH | divider output valid, captured into out_data at the end of this cycle
// DONE  | result presented, waiting for out_ready
module fpu_div_issue #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input logic            clk,
  input logic            rst,
  fpu_div_issue_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WAIT, FIRE, LATCH, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      div_a_q, div_a_d;
  logic [31:0]      div_b_q, div_b_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             div_en_q, div_en_d;
  logic             out_dz_q, out_dz_d;
  logic             out_inv_q, out_inv_d;

  logic accept;
  logic a_special, b_special, a_zero, b_zero;

  assign accept    = bus.in_valid && bus.in_ready;
  assign a_special = &bus.in_a[30:23];
  assign b_special = &bus.in_b[30:23];
  assign a_zero    = ~|bus.in_a[30:23];
  assign b_zero    = ~|bus.in_b[30:23];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    out_data_d = out_data_q;
    out_dz_d   = out_dz_q;
    out_inv_d  = out_inv_q;
    div_en_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          div_a_d    = bus.in_a;
          div_b_d    = bus.in_b;
          out_data_d = '0;
          out_dz_d   = 1'b0;
          out_inv_d  = 1'b0;
          if (a_special || b_special) begin
            out_data_d = QNAN;
            out_inv_d  = 1'b1;
            state_d    = DONE;
          end else if (b_zero) begin
            out_dz_d = 1'b1;
            state_d  = DONE;
          end else if (a_zero) begin
            state_d = DONE;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // div_en is registered, so it is raised on the edge that enters FIRE
        if (cnt_q == '0) begin
          state_d  = FIRE;
          div_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIRE:  state_d = LATCH;
      LATCH: begin
        out_data_d = bus.div_result;
        state_d    = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      div_en_q   <= 1'b0;
      out_data_q <= '0;
      out_dz_q   <= 1'b0;
      out_inv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      div_en_q   <= div_en_d;
      out_data_q <= out_data_d;
      out_dz_q   <= out_dz_d;
      out_inv_q  <= out_inv_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE) && !rst;
  assign bus.div_a       = div_a_q;
  assign bus.div_b       = div_b_q;
  assign bus.div_en      = div_en_q;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.out_data    = out_data_q;
  assign bus.out_dz      = out_dz_q;
  assign bus.out_invalid = out_inv_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_div_issue.sv
// Scoreboard bench for fpu_div_issue: two instances (settle 4 and settle 1), each
// driving a registered divider model; expected responses are queued at issue time.
module tb_fpu_div_issue;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        dz;
    logic        inv;
    int          lat;
    int          tol;
    bit          byp;
  } sb_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic clk;
  logic rst;
  int   cyc;
  int   nchk;
  int   nerr;

  sb_t  q0[$];
  sb_t  q1[$];
  int   acc[2];
  int   encnt[2];
  int   hs[2];
  logic pov[2];
  int   last_acc[2];

  fpu_div_issue_if if0();
  fpu_div_issue_if if1();

  fpu_div_issue #(.SETTLE_CYCLES(4), .CNT_W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(if0));
  fpu_div_issue #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed quotients for the operand pairs the bench sends through the divider
  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40C0_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'hC120_0000, 32'h40A0_0000}: return 32'hC000_0000;
      {32'h3F80_0000, 32'h4000_0000}: return 32'h3F00_0000;
      {32'h4000_0000, 32'h3F80_0000}: return 32'h4000_0000;
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      if0.div_result <= '0;
      if1.div_result <= '0;
    end else begin
      if0.div_result <= if0.div_en ? quot(if0.div_a, if0.div_b) : 32'h0;
      if1.div_result <= if1.div_en ? quot(if1.div_a, if1.div_b) : 32'h0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic mon(input int k, input logic vin, input logic rdy, input logic ov,
                     input logic ordy, input logic en, input logic bsy,
                     input logic [31:0] da, input logic [31:0] db, input logic [31:0] od,
                     input logic dz, input logic inv);
    sb_t e;
    bit  have;
    int  diff;
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (k == 0) ? q0[0] : q1[0];
    if (vin && rdy) begin
      acc[k]   = cyc;
      encnt[k] = 0;
    end
    if (en === 1'b1) begin
      encnt[k]++;
      nchk++;
      if (!have || e.byp || (cyc - acc[k]) != e.lat - 2) begin
        nerr++;
        $display("FAIL div_en%0d: pulse at cycle %0d after accept, expected %0d", k,
                 cyc - acc[k], have && !e.byp ? e.lat - 2 : -1);
      end
    end
    if (have && bsy === 1'b1) begin
      chk("div_a_hold", da, e.a);
      chk("div_b_hold", db, e.b);
    end
    if (ov === 1'b1) begin
      if (!have) begin
        nchk++;
        nerr++;
        $display("FAIL out_valid%0d: got 1 expected 0 (no request pending)", k);
      end else begin
        if (!pov[k]) begin
          chk("latency", cyc - acc[k], e.lat);
          chk("en_count", encnt[k], e.byp ? 0 : 1);
        end
        diff = int'(od) - int'(e.data);
        if (diff < 0) diff = -diff;
        nchk++;
        if (diff > e.tol) begin
          nerr++;
          $display("FAIL out_data%0d: got %h expected %h", k, od, e.data);
        end
        chk("out_dz", dz, e.dz);
        chk("out_invalid", inv, e.inv);
        if (ordy) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          hs[k] = cyc;
        end
      end
    end
    pov[k] = (ov === 1'b1);
  endtask

  always @(negedge clk) begin
    mon(0, if0.in_valid, if0.in_ready, if0.out_valid, if0.out_ready, if0.div_en, if0.busy,
        if0.div_a, if0.div_b, if0.out_data, if0.out_dz, if0.out_invalid);
    mon(1, if1.in_valid, if1.in_ready, if1.out_valid, if1.out_ready, if1.div_en, if1.busy,
        if1.div_a, if1.div_b, if1.out_data, if1.out_dz, if1.out_invalid);
  end

  function automatic logic rdy(input int k);
    return (k == 0) ? if0.in_ready : if1.in_ready;
  endfunction

  task automatic drive(input int k, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (k == 0) begin
      if0.in_valid = v; if0.in_a = a; if0.in_b = b;
    end else begin
      if1.in_valid = v; if1.in_a = a; if1.in_b = b;
    end
  endtask

  task automatic push(input int k, input sb_t e);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic dz, input logic inv,
                       input int lat, input int tol, input bit byp, input bit hold);
    bit got;
    got = 0;
    @(posedge clk); #1;
    push(k, '{a, b, exp, dz, inv, lat, tol, byp});
    drive(k, 1'b1, a, b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rdy(k)) begin got = 1; break; end
    end
    if (!got) begin
      nchk++; nerr++;
      $display("FAIL accept%0d: in_ready never seen within 100 cycles", k);
    end
    last_acc[k] = cyc;
    @(posedge clk); #1;
    if (!hold) drive(k, 1'b0, a, b);
    @(negedge clk);
    chk("in_ready_drop", rdy(k), 1'b0);
  endtask

  task automatic wait_idle(input int k);
    bit done;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (k == 0 && q0.size() == 0 && !if0.busy) begin done = 1; break; end
      if (k == 1 && q1.size() == 0 && !if1.busy) begin done = 1; break; end
    end
    if (!done) begin
      nchk++; nerr++;
      $display("FAIL idle%0d: result not drained within 300 cycles", k);
    end
  endtask

  initial begin
    nchk = 0; nerr = 0; cyc = 0;
    acc = '{0, 0}; encnt = '{0, 0}; hs = '{0, 0}; pov = '{1'b0, 1'b0}; last_acc = '{0, 0};
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", if0.in_ready, 1'b0);
    chk("rst_out_valid", if0.out_valid, 1'b0);
    chk("rst_div_en", if0.div_en, 1'b0);
    chk("rst_div_a", if0.div_a, 32'h0);
    chk("rst_out_data", if0.out_data, 32'h0);
    chk("rst_busy", if0.busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Normal path and bypass classes on the settle-4 instance
    issue(0, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 7, 2, 0, 0); wait_idle(0);
    issue(0, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 1, 0, 1, 0, 1, 0); wait_idle(0);
    issue(0, 32'h7F80_0000, 32'h4000_0000, QNAN,          0, 1, 1, 0, 1, 0); wait_idle(0);
    issue(0, 32'h3F80_0000, 32'h7FC0_0000, QNAN,          0, 1, 1, 0, 1, 0); wait_idle(0);
    issue(0, 32'h7F80_0000, 32'h0000_0000, QNAN,          0, 1, 1, 0, 1, 0); wait_idle(0);
    issue(0, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0, 1, 0, 1, 0); wait_idle(0);
    issue(0, 32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 0, 0, 1, 0, 1, 0); wait_idle(0);

    // Backpressure: result held 10 cycles, next request waits for the handshake
    @(posedge clk); #1;
    if0.out_ready = 1'b0;
    issue(0, 32'h7F80_0000, 32'h3F80_0000, QNAN, 0, 1, 1, 0, 1, 1);
    @(posedge clk); #1;
    push(0, '{32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 7, 2, 1'b0});
    drive(0, 1'b1, 32'h4000_0000, 32'h3F80_0000);
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", if0.in_ready, 1'b0);
    end
    @(posedge clk); #1;
    if0.out_ready = 1'b1;
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (if0.in_ready) begin got = 1; break; end
      end
      chk("bp_accept_gap", got ? cyc - hs[0] : -1, 1);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0);
    wait_idle(0);

    // Reset while in WAIT abandons the operation
    issue(0, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 0, 0, 7, 2, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_div_a", if0.div_a, 32'h0);
    chk("mid_rst_div_b", if0.div_b, 32'h0);
    chk("mid_rst_div_en", if0.div_en, 1'b0);
    chk("mid_rst_out_valid", if0.out_valid, 1'b0);
    chk("mid_rst_out_data", {if0.out_data[31:2], if0.out_dz, if0.out_invalid}, 32'h0);
    chk("mid_rst_busy", if0.busy, 1'b0);
    chk("mid_rst_in_ready", if0.in_ready, 1'b1);
    repeat (8) @(negedge clk);
    issue(0, 32'hC120_0000, 32'h40A0_0000, 32'hC000_0000, 0, 0, 7, 2, 0, 0); wait_idle(0);

    // Back-to-back on the settle-1 instance: one acceptance every 5 cycles
    begin
      logic [31:0] va[4];
      logic [31:0] vb[4];
      logic [31:0] vq[4];
      int prev;
      va = '{32'h4000_0000, 32'h40C0_0000, 32'h3F80_0000, 32'hC120_0000};
      vb = '{32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h40A0_0000};
      vq = '{32'h4000_0000, 32'h4040_0000, 32'h3F00_0000, 32'hC000_0000};
      prev = 0;
      for (int i = 0; i < 4; i++) begin
        issue(1, va[i], vb[i], vq[i], 0, 0, 4, 2, 0, 1);
        if (i > 0) chk("b2b_period", last_acc[1] - prev, 5);
        prev = last_acc[1];
      end
    end
    @(posedge clk); #1;
    drive(1, 1'b0, '0, '0);
    wait_idle(1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/fpu_div_issue.md
Name: fpu_div_issue

Overview:
- Issue/capture stage directly upstream of the single-precision divider `div`.
- Accepts IEEE-754 divide requests over a valid/ready handshake and screens special operands.
- Holds operands stable on `div` for a programmable settle window, since `div` is a long combinational Newton-Raphson chain treated as a multicycle path. Pulses `div.en` for one cycle, then captures the registered quotient.
- Presents quotient plus exception flags on a valid/ready output handshake toward the FPU writeback.

Parameters:
- SETTLE_CYCLES, 4, cycles operands are held on div_a/div_b before the en pulse; legal range 1..255.
- CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&in_ready at a rising edge.
- in_a  in  32  dividend, IEEE-754 single.
- in_b  in  32  divisor, IEEE-754 single.
- div_a  out  32  to div.A; registered copy of in_a.
- div_b  out  32  to div.B; registered copy of in_b.
- div_en  out  1  to div.en; registered, one-cycle pulse.
- div_result  in  32  from div.result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  32  quotient.
- out_dz  out  1  divide-by-zero flag, qualified by out_valid.
- out_invalid  out  1  NaN/Inf operand flag, qualified by out_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- **Reset (rst=1 at an edge):**
  - state=IDLE, counter=0.
  - div_a=div_b=0, div_en=0.
  - out_data=0, out_dz=0, out_invalid=0, out_valid=0.
  - in_ready is forced 0 while rst is high.
- **Reset mid-operation:** the operation is abandoned and no output is produced. div_en is 0 from the cycle after the reset edge.
- **States:** IDLE, WAIT, FIRE, LATCH, DONE. One request is in flight at a time.
- **in_ready:** equals (state==IDLE) && !rst.
- **IDLE:** on acceptance, latch in_a/in_b into div_a/div_b and classify with fixed priority:
  1. invalid: in_a[30:23]==8'hFF or in_b[30:23]==8'hFF. out_data=32'h7FC00000, out_invalid=1 -> DONE.
  2. dz: in_b[30:23]==0. out_data=0, out_dz=1 -> DONE.
  3. zero dividend: in_a[30:23]==0. out_data=0, no flag -> DONE.
  4. otherwise: counter=SETTLE_CYCLES-1, flags cleared -> WAIT.
- **WAIT:**
  - div_en=0; div_a/div_b held.
  - If counter==0 -> FIRE, else decrement.
- **FIRE:** div_en=1 for exactly this cycle -> LATCH. div registers the quotient at the edge ending FIRE.
- **LATCH:** div_en=0. At the edge ending LATCH, out_data<=div_result -> DONE.
  - div clears its output at that same edge because en=0; the value captured is the one present during LATCH.
- **DONE:**
  - out_valid=1; out_data and flags held stable until the handshake.
  - On out_valid&out_ready -> IDLE, out_valid drops next cycle.
  - No same-cycle accept of a new request: in_ready is 0 in DONE.
- **Latency (acceptance edge ends cycle 0):**
  - Normal path: WAIT occupies cycles 1..S, FIRE is S+1, LATCH is S+2, out_valid is first high in cycle S+3 (S=SETTLE_CYCLES).
  - Bypass path (invalid/dz/zero): out_valid is high in cycle 1.
- **Operand stability:** div_a/div_b change only on an acceptance edge or reset. They are stable from WAIT through LATCH.
- **Backpressure:** out_ready low holds DONE indefinitely with all outputs constant. Throughput is one op per S+4 cycles with out_ready tied high.
- Sign and mantissa are passed through from div unchanged; this block does no rounding.

Test Plan:
- Reset, then 0x40C00000/0x40000000 (6.0/2.0), S=4, out_ready=1 -> in_ready drops after accept; div_en high only in cycle 5; out_valid in cycle 7; out_data within ±2 ulp of 0x40400000; flags 0.
- 0x3F800000/0x00000000 -> out_valid in cycle 1, out_data=0, out_dz=1, div_en never asserted.
- 0x7F800000/0x40000000 and 0x3F800000/0x7FC00000 -> out_data=0x7FC00000, out_invalid=1, out_dz=0. Also 0x3F800000/0x00000000 with in_a exp 0xFF checks invalid-over-dz priority.
- out_ready held low 10 cycles in DONE -> out_valid, out_data, flags constant; in_valid high throughout is not accepted until one cycle after the handshake.
- rst asserted during WAIT -> next cycle all outputs 0, state IDLE, no out_valid; the following request 0xC1200000/0x40A00000 (-10/5) completes ≈0xC0000000.
- Back-to-back requests with SETTLE_CYCLES=1 -> out_valid every 5 cycles; div_a/div_b stable across every FIRE.
